// File: rtl/decode_stage_if.sv
// Bundle between fetch/write-back and the decode stage: the fetched
// instruction with its stall/flush controls, the register-file write port,
// and the decoded control word that decode hands to fetch and the later stages.
interface decode_stage_if;
   logic [31:0] Inst;
   logic [31:0] PC;
   logic        stall;
   logic        flush;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;

   logic        id_valid;
   logic [31:0] id_pc;
   logic [25:0] target;
   logic [15:0] imm16;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [4:0]  dst;
   logic [31:0] busA;
   logic [31:0] busB;
   logic        branch;
   logic        jump;
   logic        ExtOp;
   logic        ALUSrc;
   logic        RegWr;
   logic        MemWr;
   logic        MemtoReg;
   logic [2:0]  ALUctr;
   logic        illegal;

   // Fetch/write-back side: drives instructions and register writes.
   modport master (
      output Inst, PC, stall, flush, wr_en, wr_addr, wr_data,
      input  id_valid, id_pc, target, imm16, rs, rt, dst, busA, busB,
             branch, jump, ExtOp, ALUSrc, RegWr, MemWr, MemtoReg, ALUctr, illegal
   );

   // Decode side: consumes instructions and publishes the control word.
   modport slave (
      input  Inst, PC, stall, flush, wr_en, wr_addr, wr_data,
      output id_valid, id_pc, target, imm16, rs, rt, dst, busA, busB,
             branch, jump, ExtOp, ALUSrc, RegWr, MemWr, MemtoReg, ALUctr, illegal
   );
endinterface

// File: rtl/decode_stage.sv
// Instruction-decode stage: IF/ID holding register with stall/flush,
// 32x32 register file (r0 hard-wired to zero) and the MIPS-subset decoder.
// Optional feature: define DECODE_BYPASS_EN to forward a same-cycle
// register-file write onto busA/busB.
module decode_stage (
   input  logic          clk,
   input  logic          reset,
   decode_stage_if.slave bus
);

   localparam logic [31:0] NOP_INST = 32'h0000_0000;

   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_AND = 3'b010,
      ALU_OR  = 3'b011,
      ALU_SLT = 3'b100,
      ALU_LUI = 3'b101
   } alu_op_e;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDIU = 6'b001001;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_SLL  = 6'b000000;
   localparam logic [5:0] FN_ADDU = 6'b100001;
   localparam logic [5:0] FN_SUBU = 6'b100011;
   localparam logic [5:0] FN_AND  = 6'b100100;
   localparam logic [5:0] FN_OR   = 6'b100101;
   localparam logic [5:0] FN_SLT  = 6'b101010;

   logic [31:0] inst_q;
   logic [31:0] pc_q;
   logic        valid_q;
   logic [31:0] rf_q [32];

   logic [5:0]  op;
   logic [5:0]  funct;
   logic [4:0]  rs_idx;
   logic [4:0]  rt_idx;
   logic [31:0] read_a;
   logic [31:0] read_b;

   logic        dec_branch;
   logic        dec_jump;
   logic        dec_ext_op;
   logic        dec_alu_src;
   logic        dec_reg_wr;
   logic        dec_mem_wr;
   logic        dec_mem_to_reg;
   alu_op_e     dec_alu_ctr;
   logic        dec_illegal;

   // IF/ID holding register: flush beats stall, stall holds, otherwise capture.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         inst_q  <= NOP_INST;
         pc_q    <= 32'h0;
         valid_q <= 1'b0;
      end else if (bus.flush) begin
         inst_q  <= NOP_INST;
         pc_q    <= bus.PC;
         valid_q <= 1'b0;
      end else if (!bus.stall) begin
         inst_q  <= bus.Inst;
         pc_q    <= bus.PC;
         valid_q <= 1'b1;
      end
   end

   // Register file write port; writes to r0 are discarded and pipeline control does not gate writes.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 32; i++) begin
            rf_q[i] <= 32'h0;
         end
      end else if (bus.wr_en && (bus.wr_addr != 5'd0)) begin
         rf_q[bus.wr_addr] <= bus.wr_data;
      end
   end

   assign op     = inst_q[31:26];
   assign funct  = inst_q[5:0];
   assign rs_idx = inst_q[25:21];
   assign rt_idx = inst_q[20:16];

   // Read ports: r0 always reads zero; optionally forward the write happening this cycle.
   always_comb begin
      read_a = (rs_idx == 5'd0) ? 32'h0 : rf_q[rs_idx];
      read_b = (rt_idx == 5'd0) ? 32'h0 : rf_q[rt_idx];
`ifdef DECODE_BYPASS_EN
      if (bus.wr_en && (bus.wr_addr != 5'd0) && (bus.wr_addr == rs_idx)) begin
         read_a = bus.wr_data;
      end
      if (bus.wr_en && (bus.wr_addr != 5'd0) && (bus.wr_addr == rt_idx)) begin
         read_b = bus.wr_data;
      end
`endif
   end

   // Control decode of the held instruction; unknown encodings and bubbles produce an all-zero control word.
   always_comb begin
      dec_branch     = 1'b0;
      dec_jump       = 1'b0;
      dec_ext_op     = 1'b0;
      dec_alu_src    = 1'b0;
      dec_reg_wr     = 1'b0;
      dec_mem_wr     = 1'b0;
      dec_mem_to_reg = 1'b0;
      dec_alu_ctr    = ALU_ADD;
      dec_illegal    = 1'b0;
      case (op)
         OP_RTYPE: begin
            dec_reg_wr = 1'b1;
            case (funct)
               FN_SLL:  dec_alu_ctr = ALU_ADD;
               FN_ADDU: dec_alu_ctr = ALU_ADD;
               FN_SUBU: dec_alu_ctr = ALU_SUB;
               FN_AND:  dec_alu_ctr = ALU_AND;
               FN_OR:   dec_alu_ctr = ALU_OR;
               FN_SLT:  dec_alu_ctr = ALU_SLT;
               default: begin
                  dec_reg_wr  = 1'b0;
                  dec_illegal = 1'b1;
               end
            endcase
         end
         OP_ADDIU: begin
            dec_ext_op  = 1'b1;
            dec_alu_src = 1'b1;
            dec_reg_wr  = 1'b1;
            dec_alu_ctr = ALU_ADD;
         end
         OP_ORI: begin
            dec_alu_src = 1'b1;
            dec_reg_wr  = 1'b1;
            dec_alu_ctr = ALU_OR;
         end
         OP_LUI: begin
            dec_alu_src = 1'b1;
            dec_reg_wr  = 1'b1;
            dec_alu_ctr = ALU_LUI;
         end
         OP_LW: begin
            dec_ext_op     = 1'b1;
            dec_alu_src    = 1'b1;
            dec_reg_wr     = 1'b1;
            dec_mem_to_reg = 1'b1;
            dec_alu_ctr    = ALU_ADD;
         end
         OP_SW: begin
            dec_ext_op  = 1'b1;
            dec_alu_src = 1'b1;
            dec_mem_wr  = 1'b1;
            dec_alu_ctr = ALU_ADD;
         end
         OP_BEQ: begin
            dec_branch  = 1'b1;
            dec_ext_op  = 1'b1;
            dec_alu_ctr = ALU_SUB;
         end
         OP_J: begin
            dec_jump = 1'b1;
         end
         default: begin
            dec_illegal = 1'b1;
         end
      endcase
      if (!valid_q) begin
         dec_branch     = 1'b0;
         dec_jump       = 1'b0;
         dec_ext_op     = 1'b0;
         dec_alu_src    = 1'b0;
         dec_reg_wr     = 1'b0;
         dec_mem_wr     = 1'b0;
         dec_mem_to_reg = 1'b0;
         dec_alu_ctr    = ALU_ADD;
         dec_illegal    = 1'b0;
      end
   end

   assign bus.id_valid = valid_q;
   assign bus.id_pc    = pc_q;
   assign bus.target   = inst_q[25:0];
   assign bus.imm16    = inst_q[15:0];
   assign bus.rs       = rs_idx;
   assign bus.rt       = rt_idx;
   assign bus.dst      = (op == OP_RTYPE) ? inst_q[15:11] : inst_q[20:16];
   assign bus.busA     = read_a;
   assign bus.busB     = read_b;
   assign bus.branch   = dec_branch;
   assign bus.jump     = dec_jump;
   assign bus.ExtOp    = dec_ext_op;
   assign bus.ALUSrc   = dec_alu_src;
   assign bus.RegWr    = dec_reg_wr;
   assign bus.MemWr    = dec_mem_wr;
   assign bus.MemtoReg = dec_mem_to_reg;
   assign bus.ALUctr   = dec_alu_ctr;
   assign bus.illegal  = dec_illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: the stimulus process keeps a
// behavioural model (held instruction, register array, lookup tables of the
// instruction set) and queues the expected output word for each clock
// window; an independent monitor pops and compares on every falling edge.
module tb_decode_stage;

   typedef struct {
      logic [164:0] v;
      string        tag;
   } expRec_t;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   decode_stage_if bus ();

   decode_stage dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   expRec_t expQ [$];

   // Behavioural model state
   logic [31:0] mInst;
   logic [31:0] mPc;
   logic        mValid;
   logic [31:0] rf [32];

   // Copies of what the bench is currently driving
   logic [31:0] dInst;
   logic [31:0] dPC;
   logic        dStall;
   logic        dFlush;
   logic        dWrEn;
   logic [4:0]  dWrAddr;
   logic [31:0] dWrData;

   // Control word {branch,jump,ExtOp,ALUSrc,RegWr,MemWr,MemtoReg,ALUctr[2:0],illegal}
   logic [10:0] opTable    [logic [5:0]];
   logic [10:0] functTable [logic [5:0]];

   function automatic logic [164:0] actualVec();
      return {bus.id_valid, bus.id_pc, bus.target, bus.imm16, bus.rs, bus.rt, bus.dst,
              bus.busA, bus.busB, bus.branch, bus.jump, bus.ExtOp, bus.ALUSrc,
              bus.RegWr, bus.MemWr, bus.MemtoReg, bus.ALUctr, bus.illegal};
   endfunction

   function automatic logic [164:0] modelVec();
      logic [10:0] c;
      logic [5:0]  op;
      logic [5:0]  fn;
      logic [4:0]  rsI;
      logic [4:0]  rtI;
      logic [4:0]  dstI;
      logic [31:0] a;
      logic [31:0] b;
      op  = mInst[31:26];
      fn  = mInst[5:0];
      rsI = mInst[25:21];
      rtI = mInst[20:16];
      if (op == 6'd0) c = functTable.exists(fn) ? functTable[fn] : 11'd1;
      else            c = opTable.exists(op) ? opTable[op] : 11'd1;
      if (!mValid) c = 11'd0;
      dstI = (op == 6'd0) ? mInst[15:11] : mInst[20:16];
      a = rf[rsI];
      b = rf[rtI];
`ifdef DECODE_BYPASS_EN
      if (dWrEn && dWrAddr != 5'd0 && dWrAddr == rsI) a = dWrData;
      if (dWrEn && dWrAddr != 5'd0 && dWrAddr == rtI) b = dWrData;
`endif
      return {mValid, mPc, mInst[25:0], mInst[15:0], rsI, rtI, dstI, a, b, c};
   endfunction

   task automatic checkOutput(input expRec_t e);
      logic [164:0] act;
      act = actualVec();
      checks++;
      if (act !== e.v) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", e.tag, act, e.v);
      end
   endtask

   task automatic modelReset();
      mInst  = 32'h0;
      mPc    = 32'h0;
      mValid = 1'b0;
      for (int i = 0; i < 32; i++) rf[i] = 32'h0;
   endtask

   task automatic drive(input logic [31:0] inst, input logic [31:0] pc, input logic st,
                        input logic fl, input logic wen, input logic [4:0] wa,
                        input logic [31:0] wd);
      dInst = inst; dPC = pc; dStall = st; dFlush = fl;
      dWrEn = wen; dWrAddr = wa; dWrData = wd;
      bus.Inst = inst; bus.PC = pc; bus.stall = st; bus.flush = fl;
      bus.wr_en = wen; bus.wr_addr = wa; bus.wr_data = wd;
   endtask

   task automatic pushExp(input string tag);
      expRec_t e;
      e.v   = modelVec();
      e.tag = tag;
      expQ.push_back(e);
   endtask

   // One clock: the edge consumes the previous drives, then new drives are applied
   // for the window that follows and its expected outputs are queued.
   task automatic applyStimulus(input string tag, input logic [31:0] inst, input logic [31:0] pc,
                                input logic st, input logic fl, input logic wen,
                                input logic [4:0] wa, input logic [31:0] wd, input bit aimRs);
      logic [4:0] addr;
      @(posedge clk);
      if (reset) begin
         if (dWrEn && dWrAddr != 5'd0) rf[dWrAddr] = dWrData;
         if (dFlush) begin
            mInst = 32'h0; mValid = 1'b0; mPc = dPC;
         end else if (!dStall) begin
            mInst = dInst; mValid = 1'b1; mPc = dPC;
         end
      end
      #1;
      addr = aimRs ? mInst[25:21] : wa;
      drive(inst, pc, st, fl, wen, addr, wd);
      pushExp(tag);
   endtask

   function automatic logic [31:0] randInst();
      logic [5:0]  functs [6];
      logic [5:0]  ops [7];
      logic [31:0] r;
      int k;
      functs = '{6'b000000, 6'b100001, 6'b100011, 6'b100100, 6'b100101, 6'b101010};
      ops    = '{6'b001001, 6'b001101, 6'b001111, 6'b100011, 6'b101011, 6'b000100, 6'b000010};
      r = $urandom;
      k = $urandom_range(0, 9);
      if (k < 4)       return {6'b000000, r[25:6], functs[$urandom_range(0, 5)]};
      else if (k < 8)  return {ops[$urandom_range(0, 6)], r[25:0]};
      else if (k == 8) return r;
      else             return {6'b111111, r[25:0]};
   endfunction

   task automatic randomCycles(input int n);
      for (int i = 0; i < n; i++) begin
         applyStimulus("random", randInst(), $urandom,
                       ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0),
                       ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 31)), $urandom,
                       ($urandom_range(0, 2) == 0));
      end
   endtask

   // Monitor: every falling edge compares the DUT against the oldest queued expectation.
   initial begin
      expRec_t e;
      forever begin
         @(negedge clk);
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput(e);
         end
      end
   end

   // Stimulus and reference model
   initial begin
      expRec_t e;
      //                        b j E S R W M ctr   ill
      functTable[6'b000000] = 11'b0_0_0_0_1_0_0_000_0;
      functTable[6'b100001] = 11'b0_0_0_0_1_0_0_000_0;
      functTable[6'b100011] = 11'b0_0_0_0_1_0_0_001_0;
      functTable[6'b100100] = 11'b0_0_0_0_1_0_0_010_0;
      functTable[6'b100101] = 11'b0_0_0_0_1_0_0_011_0;
      functTable[6'b101010] = 11'b0_0_0_0_1_0_0_100_0;
      opTable[6'b001001]    = 11'b0_0_1_1_1_0_0_000_0;
      opTable[6'b001101]    = 11'b0_0_0_1_1_0_0_011_0;
      opTable[6'b001111]    = 11'b0_0_0_1_1_0_0_101_0;
      opTable[6'b100011]    = 11'b0_0_1_1_1_0_1_000_0;
      opTable[6'b101011]    = 11'b0_0_1_1_0_1_0_000_0;
      opTable[6'b000100]    = 11'b1_0_1_0_0_0_0_001_0;
      opTable[6'b000010]    = 11'b0_1_0_0_0_0_0_000_0;

      reset = 1'b0;
      modelReset();
      drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
      #2;
      e.v = 165'd0; e.tag = "reset_state";
      checkOutput(e);

      // Release reset after an edge
      @(posedge clk);
      #1;
      reset = 1'b1;
      pushExp("reset_release");

      applyStimulus("addu_capture", 32'h0022_1821, 32'h0000_3000, 0, 0, 0, 5'd0, 32'h0, 0);
      applyStimulus("addu_decode",  32'h0, 32'h0000_3004, 0, 0, 1, 5'd5, 32'hDEAD_BEEF, 0);
      applyStimulus("write_r0",     32'h0, 32'h0000_3008, 0, 0, 1, 5'd0, 32'h0000_1234, 0);
      applyStimulus("sw_capture",   32'hAC05_0008, 32'h0000_300C, 0, 0, 0, 5'd0, 32'h0, 0);
      applyStimulus("sw_decode",    32'h0, 32'h0000_3010, 1, 0, 0, 5'd0, 32'h0, 0);
      applyStimulus("stall_1",      32'h2401_0007, 32'h0000_3014, 1, 0, 0, 5'd0, 32'h0, 0);
      applyStimulus("stall_2",      32'h3C01_ABCD, 32'h0000_3018, 1, 0, 0, 5'd0, 32'h0, 0);
      applyStimulus("stall_flush",  32'h0022_1821, 32'h0000_301C, 1, 1, 0, 5'd0, 32'h0, 0);
      applyStimulus("beq_capture",  32'h1022_FFFE, 32'h0000_3020, 0, 0, 0, 5'd0, 32'h0, 0);
      applyStimulus("j_capture",    32'h0800_0C04, 32'h0000_3024, 0, 0, 0, 5'd0, 32'h0, 0);
      applyStimulus("rs7_capture",  32'h00E2_2021, 32'h0000_3028, 0, 0, 0, 5'd0, 32'h0, 0);
      applyStimulus("bypass_r7",    32'h0, 32'h0000_302C, 1, 0, 1, 5'd7, 32'h0000_0055, 0);
      applyStimulus("after_r7",     32'h0, 32'h0000_3030, 1, 0, 0, 5'd0, 32'h0, 0);
      applyStimulus("illegal_cap",  32'hFC00_0000, 32'h0000_3034, 0, 0, 0, 5'd0, 32'h0, 0);
      applyStimulus("illegal_dec",  32'h8C43_0010, 32'h0000_3038, 0, 0, 0, 5'd0, 32'h0, 0);

      randomCycles(250);

      // Asynchronous reset in the middle of a stalled sequence
      applyStimulus("pre_reset", randInst(), 32'h0000_4000, 1, 0, 1, 5'd9, 32'h0BAD_F00D, 0);
      @(posedge clk);
      if (dWrEn && dWrAddr != 5'd0) rf[dWrAddr] = dWrData;
      #1;
      reset = 1'b0;
      modelReset();
      drive(32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
      #1;
      e.v = 165'd0; e.tag = "async_reset";
      checkOutput(e);
      pushExp("in_reset");
      @(posedge clk);
      #1;
      reset = 1'b1;
      drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
      pushExp("release_again");

      randomCycles(100);

      repeat (3) @(negedge clk);
      #1;
      checks++;
      if (expQ.size() != 0) begin
         errors++;
         $display("[TB] FAIL drain: got %0d pending expected 0", expQ.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
